// File: rtl/fifo_read_ctrl.sv
// FIFO read-side client: pops the FIFO in stream or burst mode and drains into a 2-entry valid/ready buffer.
// Optional RD_COUNT_EN builds a saturating count of words delivered downstream on rd_count.
module fifo_read_ctrl #(
    parameter int unsigned WORD_SIZE = 12,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned BCNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 burst_mode,
    input  logic                 fifo_empty,
    input  logic                 almost_full,
    input  logic                 almost_empty,
    input  logic                 fifo_error,
    input  logic [WORD_SIZE-1:0] fifo_data,
    input  logic                 err_clr,
    input  logic                 out_ready,
    output logic                 fifo_rd,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic [1:0]           state,
    output logic                 halted,
    output logic [15:0]          rd_count
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        BURST  = 2'd2,
        HALT   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           occ_q, occ_d;
    logic                 rd_pending_q, rd_pending_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d, bcnt_inc;
    logic [WORD_SIZE-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic                 out_valid_q, out_valid_d;
    logic                 halted_q, halted_d;
    logic                 pop_c, rd_c, space_ok_c;

    // Pop request: active state, data present, and a free slot counting the in-flight read.
    always_comb begin
        pop_c      = out_valid_q & out_ready;
        space_ok_c = (3'(occ_q) + 3'(rd_pending_q)) < (3'd2 + 3'(pop_c));
        rd_c       = (state_q == STREAM || state_q == BURST) && !fifo_empty && space_ok_c;
        bcnt_inc   = (rd_c && bcnt_q != BCNT_W'(MAX_BURST)) ? bcnt_q + BCNT_W'(1) : bcnt_q;
    end

    // Mode FSM and saturating burst counter.
    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        if (state_q == BURST) begin
            bcnt_d = bcnt_inc;
        end
        if (fifo_error) begin
            state_d = HALT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && !burst_mode) begin
                        state_d = STREAM;
                    end else if (enable && burst_mode && almost_full) begin
                        state_d = BURST;
                        bcnt_d  = '0;
                    end
                end
                STREAM: begin
                    if (!enable || burst_mode) state_d = IDLE;
                end
                BURST: begin
                    if (bcnt_inc == BCNT_W'(MAX_BURST) || almost_empty || !enable) state_d = IDLE;
                end
                HALT: begin
                    if (err_clr) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        halted_d = (state_d == HALT);
    end

    // In-order 2-entry buffer; the pop shifts the tail forward before the capture lands.
    always_comb begin
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        occ_d        = occ_q;
        rd_pending_d = rd_c;
        if (pop_c) begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
        end
        if (rd_pending_q) begin
            if (occ_d == 2'd0) buf0_d = fifo_data;
            else               buf1_d = fifo_data;
            occ_d = occ_d + 2'd1;
        end
        out_valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            occ_q        <= 2'd0;
            rd_pending_q <= 1'b0;
            bcnt_q       <= '0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            out_valid_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            rd_pending_q <= rd_pending_d;
            bcnt_q       <= bcnt_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            out_valid_q  <= out_valid_d;
            halted_q     <= halted_d;
        end
    end

`ifdef RD_COUNT_EN
    logic [CNT_W-1:0] rd_count_q, rd_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        if (pop_c && rd_count_q != {CNT_W{1'b1}}) rd_count_d = rd_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) rd_count_q <= '0;
        else       rd_count_q <= rd_count_d;
    end

    assign rd_count = rd_count_q;
`else
    assign rd_count = CNT_W'(0);
`endif

    assign fifo_rd   = rd_c;
    assign out_data  = buf0_q;
    assign out_valid = out_valid_q;
    assign state     = state_q;
    assign halted    = halted_q;
endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side client of the FIFO. It consumes the flags and error produced by the FIFO control logic, issues fifo_rd pops, and captures the read data one cycle later. The data goes into a 2-entry output buffer that is presented downstream with a valid/ready handshake. Two drain modes: stream (pop whenever data exists) and burst (hysteresis between almost_full and almost_empty).

Parameters:
WORD_SIZE, 12, bits per FIFO word
MAX_BURST, 8, maximum pops per burst before returning to IDLE
BCNT_W, 4, width of burst counter; must hold MAX_BURST

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  allows reading when high
burst_mode  input  1  0 = stream mode, 1 = burst mode
fifo_empty  input  1  FIFO empty flag
almost_full  input  1  FIFO almost-full flag
almost_empty  input  1  FIFO almost-empty flag
fifo_error  input  1  FIFO overflow/underflow error
fifo_data  input  WORD_SIZE  FIFO read data, valid the cycle after fifo_rd
err_clr  input  1  clears the HALT state
out_ready  input  1  downstream accepts data
fifo_rd  output  1  pop request to FIFO
out_data  output  WORD_SIZE  head of output buffer
out_valid  output  1  out_data valid
state  output  2  IDLE=0, STREAM=1, BURST=2, HALT=3
halted  output  1  high in HALT
rd_count  output  16  words delivered downstream (optional feature)

Behaviour:
- Reset (synchronous, active-high) sets: state=IDLE, buffer occupancy=0, rd_pending=0, burst counter=0, out_valid=0, out_data=0, halted=0, rd_count=0.
- Reset mid-operation discards buffered words and any in-flight read. Data arriving the cycle after reset is not captured.
- Read pipeline:
  - fifo_rd in cycle N → fifo_data sampled at end of cycle N+1 → out_valid visible in N+2.
  - rd_pending is a register equal to the previous cycle's fifo_rd.
- fifo_rd is combinational from registered state, occupancy and rd_pending, plus fifo_empty and out_ready.
  - Asserted when state is STREAM or BURST, fifo_empty=0, and space ≥ 1.
  - space = 2 − occ − rd_pending + (out_valid & out_ready).
  - fifo_rd is never asserted while fifo_empty=1 or in IDLE/HALT.
- Output buffer:
  - 2-entry, in-order. out_data is the head entry.
  - Push and pop may occur in the same cycle; occupancy is unchanged.
  - Back-to-back pops sustain 1 word/cycle while out_ready=1.
  - out_data holds stable while out_valid=1 and out_ready=0.
- State transitions (priority top to bottom):
  - any → HALT if fifo_error=1.
  - HALT → IDLE when err_clr=1 and fifo_error=0. Buffer contents are retained and still drained downstream in HALT.
  - IDLE → STREAM if enable=1 and burst_mode=0.
  - IDLE → BURST if enable=1, burst_mode=1 and almost_full=1. Burst counter clears to 0.
  - STREAM → IDLE if enable=0 or burst_mode=1.
  - BURST: counter increments on each fifo_rd. → IDLE when counter reaches MAX_BURST, almost_empty=1, or enable=0.
- In-flight reads issued before leaving an active state are still captured.
- The burst counter saturates at MAX_BURST and does not wrap.

Optional Feature:
RD_COUNT_EN:
- Defined: rd_count increments on each out_valid & out_ready, saturating at 16'hFFFF. Cleared only by reset.
- Not defined: the counter is not built and rd_count is tied to 0.

Test Plan:
- Stream drain: burst_mode=0, enable=1, FIFO holds 3 words A,B,C, out_ready=1 → fifo_rd high 3 consecutive cycles; out_valid 2 cycles after first pop; A,B,C delivered in order, one per cycle.
- Backpressure: stream mode, out_ready=0, FIFO holds 5 → exactly 2 pops issued, occupancy 2, out_data stable = first word. out_ready=1 → remaining 3 words follow in order with no loss or duplication.
- Burst hysteresis: burst_mode=1, almost_full rises with 6 words, almost_empty asserts when count ≤ 2 → BURST entered, pops stop once almost_empty=1, state returns to IDLE.
- Burst limit: MAX_BURST=8, 12 words stored, almost_empty never asserts → exactly 8 pops, then IDLE. Re-enters BURST next cycle only if almost_full is still 1.
- Error halt: fifo_error pulses mid-stream → state=HALT the next cycle, fifo_rd=0, buffered words still delivered. err_clr=1 → IDLE, then STREAM.
- Reset mid-read: assert reset the cycle after fifo_rd → out_valid=0, occupancy 0, the in-flight word is not delivered. rd_count=0 with RD_COUNT_EN defined.
